// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and constants for the round-robin decode arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY)
//   NUM_REQ     : number of requesters / one-hot select lines
//   IDX_W       : width of the binary owner index
//   HOLD_W      : width of the grant hold counter (timeout build only)
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// rr_decode_arbiter_if: request/grant bundle between the requesting agents
// and the arbiter.
//   enable      : global enable (agents -> arbiter)
//   req[7:0]    : level-sensitive request vector (agents -> arbiter)
//   done        : single-cycle release pulse from the owner (agents -> arbiter)
//   grant[7:0]  : registered one-hot grant (arbiter -> agents)
//   grant_idx   : binary index of the current / last owner
//   grant_valid : high while grant is non-zero
//   timeout     : one-cycle pulse on a forced release
// Modports: master = requesting side, slave = arbiter side.
interface rr_decode_arbiter_if;
  import rr_arb_pkg::*;

  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               timeout;

  modport master (
    output enable, req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_idx, grant_valid, timeout
  );

endinterface

// File: rtl/onehot_decode.sv
// onehot_decode: combinational 3-to-8 one-hot decoder with enable.
//   idx_i    : binary index
//   en_i     : decoder enable; output is all zeros when low
//   onehot_o : one-hot select, bit idx_i set when enabled
module onehot_decode
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Expand the index into a single set bit, or nothing when disabled.
  always_comb begin
    onehot_o = {NUM_REQ{1'b0}};
    if (en_i) begin
      onehot_o = ONE << idx_i;
    end else begin
      onehot_o = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin arbiter owning one 3-to-8 one-hot select.
// A winner is picked from IDLE, its grant is held until release (done,
// request drop, enable low, or forced timeout), and every release is
// followed by at least one all-zero grant cycle (break-before-make).
//   MAX_HOLD : max grant length in cycles (1..255), timeout build only
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : rr_decode_arbiter_if.slave (enable/req/done in, grant out)
// Optional feature macro: ARB_TIMEOUT_EN enables the hold counter and the
// forced release with a one-cycle timeout pulse; otherwise timeout is 0.
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_decode_arbiter_if.slave    bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_decode_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               dec_en;
  logic               norm_release;
  logic [IDX_W-1:0]   pick;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0]  hold_q, hold_d;
`endif

  // First set request bit scanning cyclically upward from the pointer.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   p
  );
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = p;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = p + IDX_W'(i);
      if (!found && r[cand]) begin
        win   = cand;
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

  assign pick = rr_pick(bus.req, ptr_q);

  // Next-state, pointer and owner selection.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    dec_en       = 1'b0;
    timeout_d    = 1'b0;
    norm_release = bus.done | ~bus.req[idx_q] | ~bus.enable;
`ifdef ARB_TIMEOUT_EN
    hold_d       = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enable && (bus.req != {NUM_REQ{1'b0}})) begin
          idx_d   = pick;
          dec_en  = 1'b1;
          state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_d  = {HOLD_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef ARB_TIMEOUT_EN
        if (norm_release || (hold_q == HOLD_LAST)) begin
          // The pulse marks only releases caused purely by the hold limit.
          timeout_d = ~norm_release;
`else
        if (norm_release) begin
`endif
          ptr_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          state_d = IDLE;
        end else begin
          dec_en  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          if (hold_q != {HOLD_W{1'b1}}) begin
            hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
          end else begin
            hold_d = hold_q;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = dec_en;
  end

  onehot_decode u_dec (
    .idx_i    (idx_d),
    .en_i     (dec_en),
    .onehot_o (grant_d)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= {IDX_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      grant_q   <= {NUM_REQ{1'b0}};
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= {HOLD_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed self-checking bench for rr_decode_arbiter
// (MAX_HOLD=4). Inputs change and outputs are sampled 1ns after each edge.
module tb_rr_decode_arbiter;
  import rr_arb_pkg::*;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  rr_decode_arbiter_if bus ();

  rr_decode_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] idx);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(g != 8'h00));
    if (g != 8'h00) begin
      chk({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
    end else begin
      chk({tag, ".timeout"}, 32'(bus.timeout), 32'd0);
    end
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.req    = 8'h00;
    bus.done   = 1'b0;
    tick();
    tick();
    chk("rst.grant",   32'(bus.grant),       32'h0);
    chk("rst.idx",     32'(bus.grant_idx),   32'h0);
    chk("rst.valid",   32'(bus.grant_valid), 32'h0);
    chk("rst.timeout", 32'(bus.timeout),     32'h0);

    // req 0x81: owner 0, then owner 7 after a zero cycle.
    rst = 1'b0; bus.enable = 1'b1; bus.req = 8'h81;
    tick(); chk_grant("r81.first", 8'h01, 3'd0);
    bus.done = 1'b1;
    tick(); chk_grant("r81.gap", 8'h00, 3'd0);
    bus.done = 1'b0;
    tick(); chk_grant("r81.second", 8'h80, 3'd7);
    bus.done = 1'b1;
    tick(); chk_grant("r81.rel", 8'h00, 3'd0);

    // req 0xFF with done every grant: full rotation, wrap 7 -> 0.
    bus.done = 1'b0; bus.req = 8'hFF;
    tick(); chk_grant("rot.0", 8'h01, 3'd0);
    for (int k = 1; k <= 8; k++) begin
      bus.done = 1'b1;
      tick(); chk_grant("rot.gap", 8'h00, 3'd0);
      bus.done = 1'b0;
      tick(); chk_grant("rot.own", 8'h01 << (k % 8), 3'(k % 8));
    end

    // Owner 3 then enable drop; no grant while disabled; ptr resumes at 4.
    bus.done = 1'b1;
    tick(); chk_grant("en.rel0", 8'h00, 3'd0);
    bus.done = 1'b0; bus.req = 8'h08;
    tick(); chk_grant("en.own3", 8'h08, 3'd3);
    bus.enable = 1'b0;
    tick(); chk_grant("en.drop", 8'h00, 3'd0);
    tick(); chk_grant("en.off1", 8'h00, 3'd0);
    tick(); chk_grant("en.off2", 8'h00, 3'd0);
    bus.enable = 1'b1; bus.req = 8'h18;
    tick(); chk_grant("en.resume", 8'h10, 3'd4);

    // Owner 2 then req[2] drop without done.
    bus.done = 1'b1;
    tick(); chk_grant("rq.rel4", 8'h00, 3'd0);
    bus.done = 1'b0; bus.req = 8'h04;
    tick(); chk_grant("rq.own2", 8'h04, 3'd2);
    bus.req = 8'h00;
    tick(); chk_grant("rq.drop", 8'h00, 3'd0);
    tick(); chk_grant("rq.idle", 8'h00, 3'd0);
    chk("rq.idx_hold", 32'(bus.grant_idx), 32'd2);

    // Simultaneous done and req[2] drop: single advance, next owner 3 not 4.
    bus.req = 8'h04;
    tick(); chk_grant("sim.own2", 8'h04, 3'd2);
    bus.done = 1'b1; bus.req = 8'h18;
    tick(); chk_grant("sim.rel", 8'h00, 3'd0);
    bus.done = 1'b0;
    tick(); chk_grant("sim.own3", 8'h08, 3'd3);

    // Owner 5 never releases.
    bus.done = 1'b1;
    tick(); chk_grant("to.rel3", 8'h00, 3'd0);
    bus.done = 1'b0; bus.req = 8'h20;
    tick(); chk_grant("to.c1", 8'h20, 3'd5);
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick(); chk_grant("to.hold", 8'h20, 3'd5);
      chk("to.no_pulse", 32'(bus.timeout), 32'd0);
    end
    tick();
    chk("to.revoke", 32'(bus.grant), 32'h0);
    chk("to.pulse",  32'(bus.timeout), 32'd1);
    tick(); chk_grant("to.regrant", 8'h20, 3'd5);
    chk("to.pulse_end", 32'(bus.timeout), 32'd0);
`else
    for (int c = 2; c <= 20; c++) begin
      tick();
      chk("to.hold",      32'(bus.grant),   32'h20);
      chk("to.no_pulse",  32'(bus.timeout), 32'd0);
    end
`endif
    bus.done = 1'b1;
    tick(); chk_grant("to.rel5", 8'h00, 3'd0);

    // Owner 6 released (ptr=7), regranted, then reset mid-grant.
    bus.done = 1'b0; bus.req = 8'h40;
    tick(); chk_grant("rs.own6a", 8'h40, 3'd6);
    bus.done = 1'b1;
    tick(); chk_grant("rs.rel6", 8'h00, 3'd0);
    bus.done = 1'b0;
    tick(); chk_grant("rs.own6b", 8'h40, 3'd6);
    rst = 1'b1;
    tick();
    chk("rs.grant",   32'(bus.grant),       32'h0);
    chk("rs.idx",     32'(bus.grant_idx),   32'h0);
    chk("rs.valid",   32'(bus.grant_valid), 32'h0);
    chk("rs.timeout", 32'(bus.timeout),     32'h0);
    rst = 1'b0; bus.req = 8'hC0;
    tick(); chk_grant("rs.ptr0", 8'h40, 3'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
